delay_rr_arbiter: RTL and testbench
===================================

// Module: delay_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one RAM delay buffer among NumReq ready/valid producers.
//  - Registers one winning beat per cycle and presents it on a single ready/valid output that feeds the delay buffer's input.
//  - Output is tagged with the source ID so consumers can demultiplex after the delay.
// PARAMETERS
//  DataWidth  8   width of each requester's payload
//  NumReq     4   number of requesters, >=2
//  IdWidth    $clog2(NumReq)   localparam, width of grant_id_o
// PORTS
//  clk_i        in   1                   clock, all logic posedge
//  reset_i      in   1                   synchronous, active-high reset
//  valid_i      in   NumReq              per-requester valid
//  data_i       in   NumReq*DataWidth    packed payloads; requester k at [k*DataWidth +: DataWidth]
//  ready_o      out  NumReq              per-requester ready, one-hot or zero
//  valid_o      out  1                   registered beat available to the delay buffer
//  data_o       out  DataWidth (+IdWidth with DELAY_ARB_TAG_EN)   registered payload
//  grant_id_o   out  IdWidth             source ID of the beat on data_o
//  ready_i      in   1                   delay buffer ready
// BEHAVIOUR
//  - Reset: state=IDLE, valid_o=0, data_o=0, grant_id_o=0, rr_ptr=0, ready_o=0 while reset_i=1.
//  - Output is a single register stage, 1-cycle latency, max throughput 1 beat/cycle.
//  - Pick: the first k with valid_i[k]=1, scanning rr_ptr, rr_ptr+1, ... mod NumReq.
//  - can_load = (state==IDLE) || ready_i. ready_o[pick]=can_load when any valid_i is set; all other bits are 0.
//  - ready_o never depends combinationally on the requester's own valid_i bit beyond the pick.
//  - Accept = valid_i[pick] && ready_o[pick]. On accept:
//    - data_o <= data_i[pick], grant_id_o <= pick, valid_o <= 1.
//    - rr_ptr <= (pick==NumReq-1) ? 0 : pick+1.
//  - FSM:
//    - IDLE: valid_o=0. Accept moves to HOLD; otherwise stay in IDLE.
//    - HOLD: valid_o=1.
//      - ready_i=0: hold data_o/grant_id_o stable and stay in HOLD; no requester is readied.
//      - ready_i=1 with accept: load the new beat the same cycle (back-to-back) and stay in HOLD.
//      - ready_i=1 with no valid: move to IDLE, valid_o<=0.
//  - Fairness: a continuously valid requester waits at most NumReq-1 accepts.
//  - A requester that drops valid before being readied is skipped without penalty.
//  - Single requester always valid: it wins every cycle that ready_i=1.
//  - NumReq not a power of 2: rr_ptr wraps explicitly at NumReq-1. Unused ID codes are never produced.
//  - Reset mid-transfer: the pending beat is discarded, valid_o drops the next cycle, rr_ptr returns to 0.
//  - Default FSM state returns to IDLE.
// CONFIGURATION
//  DELAY_ARB_TAG_EN
//  - Defined: data_o is {grant_id_o, payload}, IdWidth+DataWidth wide. The delay buffer is instantiated with that width so the ID travels through the delay.
//  - Undefined: data_o is the payload only (DataWidth). The ID is available only on grant_id_o, aligned with valid_o.
// STRUCTURE
//  - delay_arb_pkg:
//    - typedef enum logic {IDLE, HOLD} arb_state_t
//    - function id_width(int n) returning the n==1 ? 1 : $clog2(n) rule
//  - Sub-module rr_pick: combinational rotating-priority encoder.
//    - Parameter NumReq.
//    - Inputs req_i[NumReq], ptr_i[IdWidth].
//    - Outputs any_o, idx_o[IdWidth].
//  - Top level holds the FSM, rr_ptr, and output registers only.
// TESTING
//  1. Reset with all valid_i=1 -> valid_o=0 and ready_o=0 during reset. First accept is requester 0 with grant_id_o=0 one cycle later.
//  2. NumReq=4, all valid, ready_i=1 constant -> grant_id_o sequence 0,1,2,3,0,... with one beat per cycle and no gaps.
//  3. Only req 2 valid with data 8'hA5; ready_i=0 for 3 cycles -> valid_o=1, data_o=A5 held stable, ready_o=0000.
//     Then ready_i=1 -> next beat accepted the same cycle.
//  4. Req 1 and 3 valid with rr_ptr=2 -> 3 wins, then 1. Req 0 raised late is served after 1, since rr_ptr wraps.
//  5. NumReq=3 all valid -> IDs 0,1,2,0 and ID 3 never appears. With DELAY_ARB_TAG_EN, data_o[9:8] matches grant_id_o.
//  6. Assert reset_i while in HOLD with valid_o=1 -> next cycle valid_o=0, rr_ptr=0, and no beat is lost on the requester side.

Source files
------------

// File: rtl/delay_arb_pkg.sv
// delay_arb_pkg: shared FSM state type and ID-width rule for the delay round-robin arbiter
package delay_arb_pkg;

    typedef enum logic {IDLE, HOLD} arb_state_t;

    function automatic int id_width(input int n);
        return (n == 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/delay_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority encoder, first set request at or after ptr_i (mod NumReq)
module rr_pick
    import delay_arb_pkg::*;
#(
    parameter int NumReq = 4,
    localparam int IdWidth = id_width(NumReq)
) (
    input  logic [NumReq-1:0]  req_i,
    input  logic [IdWidth-1:0] ptr_i,
    output logic               any_o,
    output logic [IdWidth-1:0] idx_o
);

    logic [IdWidth-1:0] cand;

    // Scan from farthest to nearest so the nearest set request is written last and wins.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            cand = (int'(ptr_i) + i >= NumReq) ? IdWidth'(int'(ptr_i) + i - NumReq)
                                               : IdWidth'(int'(ptr_i) + i);
            if (req_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/delay_rr_arbiter.sv
// delay_rr_arbiter: round-robin arbiter registering one tagged beat per cycle into a delay buffer
// DELAY_ARB_TAG_EN: when defined, data_o = {grant_id_o, payload} so the ID travels through the delay
module delay_rr_arbiter
    import delay_arb_pkg::*;
#(
    parameter int DataWidth = 8,
    parameter int NumReq = 4,
    localparam int IdWidth = id_width(NumReq),
`ifdef DELAY_ARB_TAG_EN
    localparam int OutWidth = DataWidth + IdWidth
`else
    localparam int OutWidth = DataWidth
`endif
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [NumReq-1:0]           valid_i,
    input  logic [NumReq*DataWidth-1:0] data_i,
    output logic [NumReq-1:0]           ready_o,
    output logic                        valid_o,
    output logic [OutWidth-1:0]         data_o,
    output logic [IdWidth-1:0]          grant_id_o,
    input  logic                        ready_i
);

    arb_state_t state, state_next;
    logic [IdWidth-1:0] rr_ptr, pick;
    logic any, can_load, accept;
    logic [DataWidth-1:0] payload;
    logic [DataWidth-1:0] lanes [NumReq];

    for (genvar k = 0; k < NumReq; k++) begin : g_lane
        assign lanes[k] = data_i[k*DataWidth +: DataWidth];
    end

    rr_pick #(.NumReq(NumReq)) u_pick (
        .req_i (valid_i),
        .ptr_i (rr_ptr),
        .any_o (any),
        .idx_o (pick)
    );

    assign can_load = (state == IDLE) || ready_i;
    assign accept   = any && can_load && !reset_i;
    assign ready_o  = accept ? (NumReq'(1) << pick) : '0;
    assign valid_o  = (state == HOLD);

    // Any state other than a stalled HOLD with no new beat falls back to IDLE.
    always_comb begin
        state_next = accept ? HOLD : (state == HOLD && !ready_i) ? HOLD : IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr     <= '0;
            payload    <= '0;
            grant_id_o <= '0;
        end else if (accept) begin
            payload    <= lanes[pick];
            grant_id_o <= pick;
            rr_ptr     <= (pick == IdWidth'(NumReq - 1)) ? '0 : pick + 1'b1;
        end
    end

`ifdef DELAY_ARB_TAG_EN
    assign data_o = {grant_id_o, payload};
`else
    assign data_o = payload;
`endif

endmodule

// File: tb/tb_delay_rr_arbiter.sv
// tb_delay_rr_arbiter: randomized bench comparing the arbiter against a queue-free behavioural model
module tb_delay_rr_arbiter;

`ifdef DELAY_ARB_TAG_EN
    localparam int OW = 10;
`else
    localparam int OW = 8;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic [3:0]    valid = '0;
    logic [31:0]   data = '0;
    logic          ready_in = 1'b0;
    logic [3:0]    ready;
    logic          valid_out;
    logic [OW-1:0] data_out;
    logic [1:0]    grant_id;

    logic          rst3 = 1'b1;
    logic [2:0]    v3 = '0;
    logic [23:0]   d3 = '0;
    logic          r3 = 1'b0;
    logic [2:0]    ready3;
    logic          valid3;
    logic [OW-1:0] data3;
    logic [1:0]    grant3;

    delay_rr_arbiter #(.DataWidth(8), .NumReq(4)) dut (
        .clk_i(clk), .reset_i(reset), .valid_i(valid), .data_i(data), .ready_o(ready),
        .valid_o(valid_out), .data_o(data_out), .grant_id_o(grant_id), .ready_i(ready_in)
    );

    delay_rr_arbiter #(.DataWidth(8), .NumReq(3)) dut3 (
        .clk_i(clk), .reset_i(rst3), .valid_i(v3), .data_i(d3), .ready_o(ready3),
        .valid_o(valid3), .data_o(data3), .grant_id_o(grant3), .ready_i(r3)
    );

    int total = 0;
    int bad = 0;

    // Behavioural model: one pending beat, a rotating start index, and the last accepted beat.
    bit          m_pend = 0;
    int          m_ptr = 0;
    int          m_pick = -1;
    bit          m_acc = 0;
    logic [7:0]  m_data = '0;
    int          m_id = 0;
    logic [3:0]  exp_ready = '0;
    logic [OW-1:0] exp_out = '0;

    task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic r, input logic rst);
        valid = v; data = d; ready_in = r; reset = rst;
        #1;
        m_pick = -1;
        for (int i = 0; i < 4; i++)
            if (m_pick < 0 && v[(m_ptr + i) % 4]) m_pick = (m_ptr + i) % 4;
        m_acc = !rst && (m_pick >= 0) && (!m_pend || r);
        exp_ready = m_acc ? 4'(1 << m_pick) : 4'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_pend = 0; m_ptr = 0; m_data = '0; m_id = 0;
        end else if (m_acc) begin
            m_pend = 1; m_data = data[m_pick*8 +: 8]; m_id = m_pick; m_ptr = (m_pick + 1) % 4;
        end else if (ready_in) begin
            m_pend = 0;
        end
        #1;
`ifdef DELAY_ARB_TAG_EN
        exp_out = {2'(m_id), m_data};
`else
        exp_out = m_data;
`endif
    endtask

    task automatic test_reset();
        drive(4'hF, $urandom, 1'b1, 1'b1);
        total++; if (ready !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b want=0000", ready); end
        tick();
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid_out); end
        total++; if (data_out !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", data_out); end
        total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d want=0", grant_id); end
        drive(4'hF, 32'h44332211, 1'b1, 1'b0);
        total++; if (ready !== 4'b0001) begin bad++; $display("FAIL first_ready got=%b want=0001", ready); end
        tick();
        total++; if (valid_out !== 1'b1 || grant_id !== 2'd0 || data_out[7:0] !== 8'h11)
            begin bad++; $display("FAIL first_beat got=%b/%0d/%h want=1/0/11", valid_out, grant_id, data_out[7:0]); end
    endtask

    task automatic test_rotation();
        for (int k = 0; k < 8; k++) begin
            drive(4'hF, $urandom, 1'b1, 1'b0);
            total++; if (ready !== exp_ready) begin bad++; $display("FAIL rot_ready got=%b want=%b", ready, exp_ready); end
            tick();
            total++; if (grant_id !== 2'((k + 1) % 4) || valid_out !== 1'b1)
                begin bad++; $display("FAIL rot_id got=%0d/%b want=%0d/1", grant_id, valid_out, (k + 1) % 4); end
            total++; if (data_out !== exp_out) begin bad++; $display("FAIL rot_data got=%h want=%h", data_out, exp_out); end
        end
    endtask

    task automatic test_hold();
        drive(4'b0100, 32'h00A50000, 1'b1, 1'b0);
        total++; if (ready !== 4'b0100) begin bad++; $display("FAIL hold_load got=%b want=0100", ready); end
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(4'b0100, 32'h005A0000, 1'b0, 1'b0);
            total++; if (ready !== 4'b0000) begin bad++; $display("FAIL hold_ready got=%b want=0000", ready); end
            tick();
            total++; if (valid_out !== 1'b1 || data_out[7:0] !== 8'hA5 || grant_id !== 2'd2)
                begin bad++; $display("FAIL hold_data got=%b/%h/%0d want=1/a5/2", valid_out, data_out[7:0], grant_id); end
        end
        drive(4'b0100, 32'h005A0000, 1'b1, 1'b0);
        total++; if (ready !== 4'b0100) begin bad++; $display("FAIL hold_release got=%b want=0100", ready); end
        tick();
        total++; if (data_out[7:0] !== 8'h5A) begin bad++; $display("FAIL hold_next got=%h want=5a", data_out[7:0]); end
    endtask

    task automatic test_wrap();
        drive(4'b0010, 32'h00001100, 1'b1, 1'b0);
        tick();
        drive(4'b1010, 32'h33001100, 1'b1, 1'b0);
        total++; if (ready !== 4'b1000) begin bad++; $display("FAIL wrap_r3 got=%b want=1000", ready); end
        tick();
        total++; if (grant_id !== 2'd3) begin bad++; $display("FAIL wrap_id3 got=%0d want=3", grant_id); end
        drive(4'b0010, 32'h00001100, 1'b1, 1'b0);
        tick();
        total++; if (grant_id !== 2'd1) begin bad++; $display("FAIL wrap_id1 got=%0d want=1", grant_id); end
        drive(4'b0001, 32'h000000EE, 1'b1, 1'b0);
        total++; if (ready !== 4'b0001) begin bad++; $display("FAIL wrap_r0 got=%b want=0001", ready); end
        tick();
        total++; if (grant_id !== 2'd0 || data_out[7:0] !== 8'hEE)
            begin bad++; $display("FAIL wrap_id0 got=%0d/%h want=0/ee", grant_id, data_out[7:0]); end
    endtask

    task automatic test_reset_mid();
        drive(4'b0100, 32'h00770000, 1'b1, 1'b0);
        tick();
        drive(4'b0100, 32'h00770000, 1'b0, 1'b0);
        tick();
        drive(4'b0100, 32'h00770000, 1'b0, 1'b1);
        total++; if (ready !== 4'b0) begin bad++; $display("FAIL mid_ready got=%b want=0000", ready); end
        tick();
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", valid_out); end
        drive(4'b0101, 32'h00770066, 1'b1, 1'b0);
        total++; if (ready !== 4'b0001) begin bad++; $display("FAIL mid_ptr got=%b want=0001", ready); end
        tick();
        drive(4'b0100, 32'h00770000, 1'b1, 1'b0);
        total++; if (ready !== 4'b0100) begin bad++; $display("FAIL mid_kept got=%b want=0100", ready); end
        tick();
        total++; if (grant_id !== 2'd2 || data_out[7:0] !== 8'h77)
            begin bad++; $display("FAIL mid_beat got=%0d/%h want=2/77", grant_id, data_out[7:0]); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            drive(4'($urandom), $urandom, 1'($urandom), ($urandom_range(0, 29) == 0));
            total++; if (ready !== exp_ready) begin bad++; $display("FAIL rnd_ready got=%b want=%b", ready, exp_ready); end
            tick();
            total++; if (valid_out !== m_pend) begin bad++; $display("FAIL rnd_valid got=%b want=%b", valid_out, m_pend); end
            total++; if (grant_id !== 2'(m_id) || data_out !== exp_out)
                begin bad++; $display("FAIL rnd_beat got=%0d/%h want=%0d/%h", grant_id, data_out, m_id, exp_out); end
        end
    endtask

    task automatic test_n3();
        drive(4'b0, 32'b0, 1'b1, 1'b0);
        rst3 = 1'b0; v3 = 3'b111; d3 = 24'hC2B1A0; r3 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            total++; if (valid3 !== 1'b1 || grant3 !== 2'(k % 3) || data3[7:0] !== 8'(8'hA0 + 8'h11 * (k % 3)))
                begin bad++; $display("FAIL n3_beat got=%b/%0d/%h want=1/%0d", valid3, grant3, data3[7:0], k % 3); end
`ifdef DELAY_ARB_TAG_EN
            total++; if (data3[9:8] !== grant3) begin bad++; $display("FAIL n3_tag got=%0d want=%0d", data3[9:8], grant3); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_hold();
        test_wrap();
        test_reset_mid();
        test_random();
        test_n3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
